cgra_config_dispatcher: RTL
===========================

# cgra_config_dispatcher

Upstream stage of the CGRA interconnect. Accepts one host configuration request stream (valid/ready) and routes each request to exactly one column's config port: `config_<N>_config_addr/_data/_read/_write`. For reads, it waits a fixed latency, then captures the shared `read_config_data` and returns it on a response stream. It also drives the interconnect's per-column `stall` vector, combining the host stall request with configuration-in-flight stalls.

## Interface
Parameters:
- `NUM_COLS`, default 12: number of interconnect columns / config ports.
- `COL_LSB`, default 24: LSB of the 8-bit column field in `req_addr`, i.e. `req_addr[COL_LSB+7:COL_LSB]`.
- `RD_LATENCY`, default 2: cycles from read strobe to valid `read_config_data`; legal range 1..15.

Ports (clock and reset first):
- `clk` input 1: single clock; all state on rising edge.
- `reset` input 1: synchronous, active-high.
- `req_valid` input 1: host request valid.
- `req_ready` output 1: dispatcher can accept.
- `req_addr` input 32: config address; forwarded unmodified, column field included.
- `req_data` input 32: write data.
- `req_write` input 1: 1 = write, 0 = read.
- `rsp_valid` output 1: response valid.
- `rsp_ready` input 1: host accepts response.
- `rsp_data` output 32: read data (0 for writes and errors).
- `rsp_err` output 1: column index out of range.
- `cfg_addr` output NUM_COLS*32: per-column config address; column N at `[32N+31:32N]`.
- `cfg_data` output NUM_COLS*32: per-column config data.
- `cfg_read` output NUM_COLS: per-column read strobe.
- `cfg_write` output NUM_COLS: per-column write strobe.
- `read_config_data` input 32: shared readback from the interconnect.
- `stall_req` input NUM_COLS: host per-column stall.
- `stall` output NUM_COLS: per-column stall to the interconnect.

## Operation
- FSM states: IDLE, ISSUE, WAIT_RD, RESP.
- IDLE:
  - `req_ready`=1; in all other states `req_ready`=0.
  - On `req_valid & req_ready`, register addr, data, write and col = `req_addr[COL_LSB+7:COL_LSB]`.
  - If col < NUM_COLS, go to ISSUE. Otherwise set err=1 and go directly to RESP; no strobe is issued.
- ISSUE (exactly one cycle):
  - Selected column: `cfg_write[col]` = write or `cfg_read[col]` = !write, plus the registered addr and data.
  - All other columns: addr, data and strobes are 0.
  - Next state: a write goes to RESP; a read loads counter = RD_LATENCY-1 and goes to WAIT_RD.
- WAIT_RD:
  - Decrement the counter each cycle.
  - When counter = 0, capture `read_config_data` into `rsp_data` and go to RESP.
  - Total: the sample is taken RD_LATENCY cycles after the strobe cycle.
- RESP:
  - `rsp_valid`=1; `rsp_data` and `rsp_err` are held stable until `rsp_ready`.
  - On `rsp_ready`, go to IDLE and clear err and rsp_data.
- Only one request is in flight at a time; there is no pipelining.
- `cfg_addr` and `cfg_data` for the selected column hold their value only during ISSUE; they are 0 otherwise.
- `stall` = `stall_req` | `cfg_stall_mask` (see Configuration). `stall_req` is passed through combinationally.

## Timing
- Reset values: `req_ready`=0 during reset, 1 on the first cycle after reset is released. `rsp_valid`=0, `rsp_data`=0, `rsp_err`=0, all `cfg_*`=0, internal stall mask=0, state=IDLE.
- Write latency: accept at cycle T, strobe at T+1, `rsp_valid` at T+2. The next request can be accepted at T+3 at the earliest, when `rsp_ready` is held high.
- Read latency: accept at T, strobe at T+1, sample at T+1+RD_LATENCY, `rsp_valid` at T+2+RD_LATENCY.
- Error: accept at T, `rsp_valid` with `rsp_err`=1 at T+1.
- Response backpressure: `rsp_valid` stays high indefinitely while `rsp_ready`=0. `rsp_ready` asserted when `rsp_valid`=0 is ignored.
- Reset mid-operation: at the next edge the FSM returns to IDLE, strobes and stall mask drop, and any pending response is discarded.
- Column boundaries: col = NUM_COLS-1 (11) is valid; col = NUM_COLS (12) up to 255 is an error.

## Configuration
- `CFG_DISPATCH_STALL_EN` defined:
  - `cfg_stall_mask[col]` is set on entering ISSUE and cleared on leaving WAIT_RD (reads) or ISSUE (writes).
  - The targeted column is therefore stalled during its strobe and readback window.
- Undefined: `cfg_stall_mask` is constant 0 and `stall` = `stall_req` exactly.

## Test plan
- Write: addr=0x0300_0010, data=0xDEAD_BEEF, write=1 -> one cycle later `cfg_write[3]`=1, `cfg_addr[3]`=0x0300_0010, `cfg_data[3]`=0xDEADBEEF, all other strobes 0; `rsp_valid` the next cycle with `rsp_data`=0, `rsp_err`=0.
- Read, RD_LATENCY=2: addr=0x0B00_0004 -> `cfg_read[11]` strobe at T+1; with `read_config_data`=0x1234_5678 at T+3, `rsp_data`=0x12345678 and `rsp_valid` at T+4.
- Out-of-range: addr=0x0C00_0000 -> no `cfg_*` strobe; `rsp_valid`=1 and `rsp_err`=1 at T+1.
- Backpressure: hold `rsp_ready`=0 for 5 cycles -> response stable, `req_ready`=0 throughout; accept occurs 1 cycle after `rsp_ready`.
- Reset during WAIT_RD -> next cycle all outputs are at reset values; no response is produced.
- Stall: with `CFG_DISPATCH_STALL_EN`, a read to column 5 holds `stall[5]`=1 from T+1 through T+1+RD_LATENCY. Without the macro, `stall` = `stall_req` = 0x0A5 exactly.

Source files
------------

// File: rtl/cgra_config_dispatcher.sv
// CGRA configuration dispatcher: routes host config requests to one column's config port,
// returns read data after a fixed latency. Define CFG_DISPATCH_STALL_EN to stall the targeted column.
module cgra_config_dispatcher #(
    parameter int NUM_COLS   = 12,
    parameter int COL_LSB    = 24,
    parameter int RD_LATENCY = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [31:0]              req_addr,
    input  logic [31:0]              req_data,
    input  logic                     req_write,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [31:0]              rsp_data,
    output logic                     rsp_err,
    output logic [NUM_COLS*32-1:0]   cfg_addr,
    output logic [NUM_COLS*32-1:0]   cfg_data,
    output logic [NUM_COLS-1:0]      cfg_read,
    output logic [NUM_COLS-1:0]      cfg_write,
    input  logic [31:0]              read_config_data,
    input  logic [NUM_COLS-1:0]      stall_req,
    output logic [NUM_COLS-1:0]      stall
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RD,
        RESP
    } state_e;

    localparam logic [8:0] NUM_COLS_W = 9'(NUM_COLS);
    localparam logic [3:0] CNT_LOAD   = 4'(RD_LATENCY - 1);

    state_e              state_q, state_d;
    logic [31:0]         addr_q, addr_d;
    logic [31:0]         data_q, data_d;
    logic                write_q, write_d;
    logic [7:0]          col_q, col_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                err_q, err_d;
    logic [31:0]         rsp_data_q, rsp_data_d;
    logic [7:0]          req_col;
    logic [NUM_COLS-1:0] col_onehot;
    logic [NUM_COLS-1:0] cfg_stall_mask;

    assign req_col = req_addr[COL_LSB +: 8];

    // NOTE: every variable driven in always_comb gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        data_d     = data_q;
        write_d    = write_q;
        col_d      = col_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        rsp_data_d = rsp_data_q;
        req_ready  = 1'b0;

        case (state_q)
            IDLE: begin
                req_ready = ~reset;
                if (req_valid && !reset) begin
                    addr_d  = req_addr;
                    data_d  = req_data;
                    write_d = req_write;
                    col_d   = req_col;
                    if ({1'b0, req_col} < NUM_COLS_W) begin
                        state_d = ISSUE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            ISSUE: begin
                if (write_q) begin
                    state_d = RESP;
                end else begin
                    cnt_d   = CNT_LOAD;
                    state_d = WAIT_RD;
                end
            end
            WAIT_RD: begin
                if (cnt_q == 4'd0) begin
                    rsp_data_d = read_config_data;
                    state_d    = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    err_d      = 1'b0;
                    rsp_data_d = '0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        col_onehot = '0;
        for (int i = 0; i < NUM_COLS; i++) begin
            col_onehot[i] = (col_q == 8'(i));
        end
    end

    // Config ports are driven only while the single ISSUE cycle is active.
    always_comb begin
        cfg_addr  = '0;
        cfg_data  = '0;
        cfg_read  = '0;
        cfg_write = '0;
        for (int i = 0; i < NUM_COLS; i++) begin
            if ((state_q == ISSUE) && col_onehot[i]) begin
                cfg_addr[32*i +: 32] = addr_q;
                cfg_data[32*i +: 32] = data_q;
                cfg_write[i]         = write_q;
                cfg_read[i]          = ~write_q;
            end
        end
    end

    assign rsp_valid = (state_q == RESP);
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = err_q;

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            data_q     <= '0;
            write_q    <= 1'b0;
            col_q      <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            write_q    <= write_d;
            col_q      <= col_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            rsp_data_q <= rsp_data_d;
        end
    end

`ifdef CFG_DISPATCH_STALL_EN
    logic [NUM_COLS-1:0] stall_mask_q, stall_mask_d;

    // Mask tracks the target column for as long as the next state is ISSUE or WAIT_RD.
    always_comb begin
        stall_mask_d = '0;
        if ((state_d == ISSUE) || (state_d == WAIT_RD)) begin
            for (int i = 0; i < NUM_COLS; i++) begin
                stall_mask_d[i] = (col_d == 8'(i));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_mask_q <= '0;
        end else begin
            stall_mask_q <= stall_mask_d;
        end
    end

    assign cfg_stall_mask = stall_mask_q;
`else
    assign cfg_stall_mask = '0;
`endif

    assign stall = stall_req | cfg_stall_mask;

endmodule
